// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants, sequencer state type and round-key slicing.
package aes_pkg;
  localparam int AES_NR      = 10;
  localparam int AES_NK      = 4;
  localparam int AES_RK_W    = 128;
  localparam int AES_SCHED_W = (AES_NR + 1) * AES_RK_W;

  typedef enum logic [2:0] {
    KXC_CLEAR,
    KXC_IDLE,
    KXC_START,
    KXC_WAIT,
    KXC_LATCH,
    KXC_ERROR
  } kxc_state_t;

  // Round key 0 sits in the top bits, so shifting left brings key idx to the top.
  function automatic logic [AES_RK_W-1:0] rk_slice(input logic [AES_SCHED_W-1:0] sched,
                                                   input logic [3:0] idx);
    logic [AES_SCHED_W-1:0] sh;
    sh = sched << (AES_RK_W * int'(idx));
    return sh[AES_SCHED_W-1 -: AES_RK_W];
  endfunction
endpackage

// File: rtl/round_key_ctrl_if.sv
// Key-load handshake, round-key read port and status between cipher side and round_key_ctrl.
interface round_key_ctrl_if;
  import aes_pkg::*;

  logic [AES_RK_W-1:0] key_in;
  logic                key_valid;
  logic                key_ready;
  logic                cipher_busy;
  logic                rk_req;
  logic [3:0]          rk_idx;
  logic                rk_valid;
  logic [AES_RK_W-1:0] rk_data;
  logic                rk_err;
  logic                key_loaded;
  logic                kx_error;

  modport master (
    output key_in, key_valid, cipher_busy, rk_req, rk_idx,
    input  key_ready, rk_valid, rk_data, rk_err, key_loaded, kx_error
  );

  modport slave (
    input  key_in, key_valid, cipher_busy, rk_req, rk_idx,
    output key_ready, rk_valid, rk_data, rk_err, key_loaded, kx_error
  );
endinterface

// File: rtl/round_key_ctrl_rk_buffer.sv
// Schedule register with a load port and a registered, 1-cycle indexed round-key read port.
module rk_buffer
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [AES_SCHED_W-1:0] sched_in,
  input  logic                   loaded,
  input  logic                   rk_req,
  input  logic [3:0]             rk_idx,
  output logic                   rk_valid,
  output logic [AES_RK_W-1:0]    rk_data,
  output logic                   rk_err
);
  logic [AES_SCHED_W-1:0] sched_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched_q  <= '0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
    end else begin
      if (load) sched_q <= sched_in;
      // Reads use the pre-load contents, so a read during the latch cycle sees the old buffer.
      if (rk_req) begin
        if (!loaded || (rk_idx > 4'(NR))) begin
          rk_err   <= 1'b1;
          rk_valid <= 1'b0;
        end else begin
          rk_err   <= 1'b0;
          rk_valid <= 1'b1;
          rk_data  <= rk_slice(sched_q, rk_idx);
        end
      end else begin
        rk_err   <= 1'b0;
        rk_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/round_key_ctrl.sv
// Key-load sequencer driving the key-expansion engine, with timeout and a local schedule buffer.
module round_key_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int TIMEOUT = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  round_key_ctrl_if.slave        kif,
  output logic                   kx_rst,
  output logic                   kx_start,
  output logic [AES_RK_W-1:0]    kx_key,
  input  logic                   kx_finish,
  input  logic [AES_SCHED_W-1:0] kx_sched
);
  localparam int CW = $clog2(TIMEOUT);

  kxc_state_t    state;
  logic [CW-1:0] cnt;
  logic          resume;
  logic          hs;

  always_comb begin
    kif.key_ready = ((state == KXC_IDLE) || (state == KXC_ERROR)) && !kif.cipher_busy;
    hs            = kif.key_ready && kif.key_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= KXC_CLEAR;
      cnt            <= '0;
      resume         <= 1'b0;
      kx_rst         <= 1'b1;
      kx_start       <= 1'b0;
      kx_key         <= '0;
      kif.key_loaded <= 1'b0;
      kif.kx_error   <= 1'b0;
    end else begin
      case (state)
        // resume marks a CLEAR entered from ERROR, which proceeds straight to START.
        KXC_CLEAR: begin
          kx_rst <= 1'b0;
          if (resume) begin
            resume   <= 1'b0;
            kx_start <= 1'b1;
            state    <= KXC_START;
          end else begin
            state <= KXC_IDLE;
          end
        end
        KXC_IDLE: begin
          if (hs) begin
            kx_key         <= kif.key_in;
            kif.key_loaded <= 1'b0;
            kif.kx_error   <= 1'b0;
            kx_start       <= 1'b1;
            state          <= KXC_START;
          end
        end
        KXC_START: begin
          kx_start <= 1'b0;
          cnt      <= '0;
          state    <= KXC_WAIT;
        end
        KXC_WAIT: begin
          cnt <= cnt + CW'(1);
          if (kx_finish) begin
            state <= KXC_LATCH;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            kif.kx_error <= 1'b1;
            state        <= KXC_ERROR;
          end
        end
        KXC_LATCH: begin
          kif.key_loaded <= 1'b1;
          kx_rst         <= 1'b1;
          state          <= KXC_CLEAR;
        end
        KXC_ERROR: begin
          if (hs) begin
            kx_key       <= kif.key_in;
            kif.kx_error <= 1'b0;
            kx_rst       <= 1'b1;
            resume       <= 1'b1;
            state        <= KXC_CLEAR;
          end
        end
        default: begin
          kx_rst <= 1'b1;
          state  <= KXC_CLEAR;
        end
      endcase
    end
  end

  rk_buffer #(.NR(NR)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (state == KXC_LATCH),
    .sched_in (kx_sched),
    .loaded   (kif.key_loaded),
    .rk_req   (kif.rk_req),
    .rk_idx   (kif.rk_idx),
    .rk_valid (kif.rk_valid),
    .rk_data  (kif.rk_data),
    .rk_err   (kif.rk_err)
  );
endmodule

// File: tb/tb_round_key_ctrl.sv
// Bench for round_key_ctrl: behavioural AES key-expansion engine, event-timeline model, random traffic.
module tb_round_key_ctrl;
  import aes_pkg::*;

  localparam int TO = 64;
  typedef logic [0:10][127:0] sched_t;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R10_SEQ = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  round_key_ctrl_if kif ();
  logic          kx_rst, kx_start, kx_finish;
  logic [127:0]  kx_key;
  logic [1407:0] kx_sched;

  round_key_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .kif       (kif),
    .kx_rst    (kx_rst),
    .kx_start  (kx_start),
    .kx_key    (kx_key),
    .kx_finish (kx_finish),
    .kx_sched  (kx_sched)
  );

  // ---------------- AES-128 key expansion (FIPS-197) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = '0;
    if (x != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // ---------------- expansion engine stand-in ----------------
  bit eng_stuck;
  int eng_delay;
  bit armed;
  int ecnt;

  initial begin
    kx_finish = 1'b0;
    kx_sched  = '0;
    armed     = 1'b0;
    ecnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (kx_rst) begin
        kx_finish = 1'b0;
        armed     = 1'b0;
      end else if (kx_start) begin
        armed = 1'b1;
        ecnt  = eng_delay;
        for (int j = 0; j < 44; j++) kx_sched[32*j +: 32] = $urandom();
      end else if (armed) begin
        ecnt--;
        if (ecnt <= 0) begin
          armed = 1'b0;
          if (!eng_stuck) begin
            kx_sched  = expand(kx_key);
            kx_finish = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- reference model: edge-numbered timeline of a load ----------------
  int           e, m_start_at, m_latch_at, m_acc_at;
  bit           m_acc, m_loaded, m_err, m_loading;
  logic [127:0] m_key, exp_rd;
  bit           exp_rv, exp_re, exp_krst, exp_kstart;
  sched_t       m_s;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e = 0; m_acc = 0; m_loaded = 0; m_err = 0; m_loading = 0;
      m_start_at = -10; m_latch_at = -10; m_acc_at = 1;
      m_key = '0; exp_rd = '0; exp_rv = 0; exp_re = 0;
      exp_krst = 1; exp_kstart = 0; m_s = '0;
    end else begin
      e++;
      exp_rv = 0;
      exp_re = 0;
      if (kif.rk_req) begin
        if (kif.rk_idx > 10 || !m_loaded) exp_re = 1;
        else begin
          exp_rv = 1;
          exp_rd = m_s[kif.rk_idx];
        end
      end
      exp_krst   = 0;
      exp_kstart = 0;
      if (m_acc && kif.key_valid && !kif.cipher_busy) begin
        m_acc = 0; m_loaded = 0; m_key = kif.key_in; m_loading = 1;
        if (m_err) begin
          m_err = 0; exp_krst = 1; m_start_at = e + 1;
        end else begin
          m_start_at = e; exp_kstart = 1;
        end
      end else if (m_loading) begin
        if (e == m_start_at) exp_kstart = 1;
        else if (e >= m_start_at + 2) begin
          if (kx_finish) begin
            m_loading = 0; m_latch_at = e + 1;
          end else if (e - (m_start_at + 1) == TO) begin
            m_loading = 0; m_err = 1; m_acc = 1;
          end
        end
      end
      if (e == m_latch_at) begin
        m_loaded = 1; m_s = expand(m_key); exp_krst = 1; m_acc_at = e + 1;
      end
      if (e == m_acc_at) m_acc = 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit hs_seen;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic cmp_model();
    chk("key_ready",  128'(kif.key_ready),  128'(m_acc && !kif.cipher_busy));
    chk("rk_valid",   128'(kif.rk_valid),   128'(exp_rv));
    chk("rk_err",     128'(kif.rk_err),     128'(exp_re));
    chk("rk_data",    kif.rk_data,          exp_rd);
    chk("key_loaded", 128'(kif.key_loaded), 128'(m_loaded));
    chk("kx_error",   128'(kif.kx_error),   128'(m_err));
    chk("kx_rst",     128'(kx_rst),         128'(exp_krst));
    chk("kx_start",   128'(kx_start),       128'(exp_kstart));
    chk("kx_key",     kx_key,               m_key);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic load_key(input logic [127:0] k, input int budget);
    kif.key_in    = k;
    kif.key_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (kif.key_ready) break;
      cyc();
    end
    hs_seen = kif.key_ready;
    chk("handshake", 128'(hs_seen), 128'(1));
    cyc();
    kif.key_valid = 1'b0;
  endtask

  task automatic wait_loaded(input int budget, output int lat);
    lat = 0;
    while (!kif.key_loaded && lat < budget) begin
      cyc();
      lat++;
    end
    chk("load_done", 128'(kif.key_loaded), 128'(1));
  endtask

  task automatic rd(input int idx);
    kif.rk_req = 1'b1;
    kif.rk_idx = 4'(idx);
    cyc();
    kif.rk_req = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    kif.key_in = '0; kif.key_valid = 1'b0; kif.cipher_busy = 1'b0;
    kif.rk_req = 1'b0; kif.rk_idx = '0;
    eng_stuck = 1'b0; eng_delay = 30;

    // reset state
    @(negedge clk);
    cmp_model();
    chk("rst_kx_rst", 128'(kx_rst), 128'(1));
    chk("rst_key_ready", 128'(kif.key_ready), 128'(0));
    cyc();
    rst = 1'b1;
    cyc();
    chk("idle_ready", 128'(kif.key_ready), 128'(1));

    // FIPS-197 load and reads
    load_key(K_FIPS, 10);
    wait_loaded(60, lat);
    chk("load_lat_lt40", 128'(lat < 40), 128'(1));
    rd(0);
    chk("fips_rk0", kif.rk_data, K_FIPS);
    rd(10);
    chk("fips_rk10", kif.rk_data, R10_FIPS);
    chk("fips_rk10_valid", 128'(kif.rk_valid), 128'(1));

    // reload, read during reload
    cyc();
    load_key(K_SEQ, 10);
    rd(3);
    chk("reload_rd_err", 128'(kif.rk_err), 128'(1));
    wait_loaded(60, lat);
    chk("reload_clear_pulse", 128'(kx_rst), 128'(1));
    cyc();
    chk("clear_one_cycle", 128'(kx_rst), 128'(0));
    rd(10);
    chk("seq_rk10", kif.rk_data, R10_SEQ);

    // out-of-range indices
    rd(11);
    chk("idx11_err", 128'(kif.rk_err), 128'(1));
    chk("idx11_hold", kif.rk_data, R10_SEQ);
    rd(15);
    chk("idx15_err", 128'(kif.rk_err), 128'(1));
    chk("idx15_valid", 128'(kif.rk_valid), 128'(0));
    chk("idx15_hold", kif.rk_data, R10_SEQ);

    // cipher_busy blocks acceptance
    cyc();
    kif.cipher_busy = 1'b1;
    kif.key_in      = rnd128();
    kif.key_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("busy_no_ready", 128'(kif.key_ready), 128'(0));
    end
    kif.cipher_busy = 1'b0;
    #1;
    chk("busy_drop_ready", 128'(kif.key_ready), 128'(1));
    cyc();
    kif.key_valid = 1'b0;
    chk("busy_hs_start", 128'(kx_start), 128'(1));
    wait_loaded(60, lat);
    rd(5);

    // hung engine times out, then recovery
    eng_stuck = 1'b1;
    load_key(rnd128(), 10);
    cnt = 0;
    while (!kif.kx_error && cnt < TO + 10) begin
      cyc();
      cnt++;
    end
    chk("timeout_cycles", 128'(cnt), 128'(TO + 1));
    chk("timeout_not_loaded", 128'(kif.key_loaded), 128'(0));
    eng_stuck = 1'b0;
    eng_delay = 20;
    load_key(rnd128(), 10);
    chk("recover_err_clr", 128'(kif.kx_error), 128'(0));
    chk("recover_clear", 128'(kx_rst), 128'(1));
    wait_loaded(60, lat);
    rd(7);

    // asynchronous reset mid-WAIT
    eng_delay = 30;
    load_key(rnd128(), 10);
    repeat (5) cyc();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_key_ready", 128'(kif.key_ready), 128'(0));
    chk("arst_rk_valid", 128'(kif.rk_valid), 128'(0));
    chk("arst_rk_data", kif.rk_data, 128'(0));
    chk("arst_rk_err", 128'(kif.rk_err), 128'(0));
    chk("arst_key_loaded", 128'(kif.key_loaded), 128'(0));
    chk("arst_kx_error", 128'(kif.kx_error), 128'(0));
    chk("arst_kx_rst", 128'(kx_rst), 128'(1));
    chk("arst_kx_start", 128'(kx_start), 128'(0));
    chk("arst_kx_key", kx_key, 128'(0));
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("arst_idle_ready", 128'(kif.key_ready), 128'(1));
    chk("arst_idle_kx_rst", 128'(kx_rst), 128'(0));
    rd(0);
    chk("arst_no_sched", 128'(kif.rk_err), 128'(1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kif.cipher_busy = ($urandom_range(0, 7) == 0);
      kif.key_valid   = ($urandom_range(0, 15) == 0);
      kif.key_in      = rnd128();
      kif.rk_req      = $urandom_range(0, 1) == 1;
      kif.rk_idx      = 4'($urandom_range(0, 12));
      eng_stuck       = ($urandom_range(0, 39) == 0);
      eng_delay       = $urandom_range(1, 35);
      cyc();
    end
    kif.key_valid = 1'b0;
    kif.rk_req    = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
